// File: rtl/div3_serial.sv
// div3_serial: bit-serial unsigned divide-by-3 with valid/ready handshakes; define DIV3_QUOTIENT_EN to also build the quotient path
module div3_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dat_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       reminder,
  output logic [WIDTH-1:0] quotient,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sh;
  logic [1:0]       r_acc;
  logic [2:0]       t;
  logic             ge;
  logic [1:0]       r_nxt;
  logic             last;
  logic             accept;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state == CALC;
  assign accept    = in_ready && in_valid;
  assign last      = busy && cnt == '0;
  // One restoring step: t = 2r + next dividend bit, t < 6 because r stays in 0..2
  always_comb begin
    t     = {r_acc, sh[WIDTH-1]};
    ge    = t >= 3'd3;
    r_nxt = ge ? 2'(t - 3'd3) : t[1:0];
  end
  // Sequencer, shift register, remainder accumulator and result remainder
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sh       <= '0;
      r_acc    <= '0;
      reminder <= '0;
    end else if (accept) begin
      state <= CALC;
      sh    <= dat_i;
      r_acc <= '0;
      cnt   <= CW'(WIDTH - 1);
    end else if (busy) begin
      sh    <= sh << 1;
      r_acc <= r_nxt;
      cnt   <= last ? '0 : cnt - CW'(1);
      if (last) begin
        state    <= DONE;
        reminder <= r_nxt;
      end
    end else if (out_valid && out_ready) begin
      state <= IDLE;
    end
  end
`ifdef DIV3_QUOTIENT_EN
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] q_nxt;
  assign q_nxt = {q_acc[WIDTH-2:0], ge};
  // Quotient bits enter at the LSB and move up, so the first (MSB) bit ends at the top
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_acc    <= '0;
      quotient <= '0;
    end else if (accept) begin
      q_acc <= '0;
    end else if (busy) begin
      q_acc <= q_nxt;
      if (last) quotient <= q_nxt;
    end
  end
`else
  assign quotient = '0;
`endif
endmodule
